// File: rtl/affine_pipe.sv
// affine_pipe: Y = ((X*A + B)*C + D), each stage reduced to W bits (wrap, or saturate with AFFINE_PIPE_SAT_EN).
// Latency: 4 cycles, one sample per cycle. Backpressure: per-stage stall; in_ready is combinational from out_ready.
// Backpressure: a stage loads when it is empty or its content leaves this cycle, so a full pipe refills with no bubble.
module affine_pipe #(
    parameter int W = 16,
    parameter int A = 3,
    parameter int B = 5,
    parameter int C = 2,
    parameter int D = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] X,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] Y
`ifdef AFFINE_PIPE_SAT_EN
    ,
    output logic                sat_hit
`endif
);

    logic v1, v2, v3, vo;
    logic signed [W-1:0] s1, s2, s3;
    logic en1, en2, en3, en_o;
    logic [W-1:0] r1, r2, r3;

    assign en_o      = !vo || out_ready;
    assign en3       = !v3 || en_o;
    assign en2       = !v2 || en3;
    assign en1       = !v1 || en2;
    assign in_ready  = en1 && !rst;
    assign out_valid = vo;

`ifdef AFFINE_PIPE_SAT_EN
    // Wide enough for the largest intermediate (s2*C + D) with headroom for the sign.
    localparam int PW = 2*W + 2;
    localparam logic signed [PW-1:0] AP   = PW'(A);
    localparam logic signed [PW-1:0] BP   = PW'(B);
    localparam logic signed [PW-1:0] CP   = PW'(C);
    localparam logic signed [PW-1:0] DP   = PW'(D);
    localparam logic signed [PW-1:0] SMAX = {{(W+3){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = ~SMAX;

    function automatic logic [W-1:0] clamp(input logic signed [PW-1:0] v);
        if (v > SMAX)
            clamp = SMAX[W-1:0];
        else if (v < SMIN)
            clamp = SMIN[W-1:0];
        else
            clamp = v[W-1:0];
    endfunction

    function automatic logic clipped(input logic signed [PW-1:0] v);
        clipped = (v > SMAX) || (v < SMIN);
    endfunction

    logic signed [PW-1:0] p1, p2, p3;
    logic h1, h2, h3, ho;

    assign p1 = PW'(X) * AP;
    assign p2 = PW'(s1) + BP;
    assign p3 = PW'(s2) * CP + DP;
    assign r1 = clamp(p1);
    assign r2 = clamp(p2);
    assign r3 = clamp(p3);
    assign sat_hit = ho;

    // Clamp flag rides alongside the datum through the same enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            h1 <= 1'b0;
            h2 <= 1'b0;
            h3 <= 1'b0;
            ho <= 1'b0;
        end else begin
            if (en1 && in_valid) h1 <= clipped(p1);
            if (en2 && v1)       h2 <= h1 | clipped(p2);
            if (en3 && v2)       h3 <= h2 | clipped(p3);
            if (en_o && v3)      ho <= h3;
        end
    end
`else
    localparam logic signed [W-1:0] AW = W'(A);
    localparam logic signed [W-1:0] BW = W'(B);
    localparam logic signed [W-1:0] CW = W'(C);
    localparam logic signed [W-1:0] DW = W'(D);

    // Low W bits of the full-precision result equal the W-bit-context result.
    assign r1 = X * AW;
    assign r2 = s1 + BW;
    assign r3 = s2 * CW + DW;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            vo <= 1'b0;
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            Y  <= '0;
        end else begin
            if (en1) begin
                v1 <= in_valid;
                if (in_valid) s1 <= r1;
            end
            if (en2) begin
                v2 <= v1;
                if (v1) s2 <= r2;
            end
            if (en3) begin
                v3 <= v2;
                if (v2) s3 <= r3;
            end
            if (en_o) begin
                vo <= v3;
                if (v3) Y <= s3;
            end
        end
    end

endmodule

// File: tb/tb_affine_pipe.sv
// Bench for affine_pipe: directed latency/stream/stall/overflow/reset steps, then random handshake
// traffic scored against an arithmetic reference model (saturating model when AFFINE_PIPE_SAT_EN is set).
module tb_affine_pipe;
    localparam int W = 16;
    localparam longint PA = 3, PB = 5, PC = 2, PD = 7;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready;
    logic signed [W-1:0] X, Y;
`ifdef AFFINE_PIPE_SAT_EN
    logic sat_hit;
`endif

    affine_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .X(X),
        .out_valid(out_valid), .out_ready(out_ready), .Y(Y)
`ifdef AFFINE_PIPE_SAT_EN
        , .sat_hit(sat_hit)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    longint cyc = 0;
    longint q_y[$];
    bit     q_h[$];
    longint log_y[$];
    longint log_c[$];
    bit     log_h[$];
    bit obs_ov, obs_ir, prev_stall;
    longint obs_y, prev_y;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint red(input longint v, output bit hit);
        longint lim;
        lim = longint'(1) << (W - 1);
        hit = 1'b0;
`ifdef AFFINE_PIPE_SAT_EN
        if (v > lim - 1) begin hit = 1'b1; return lim - 1; end
        if (v < -lim) begin hit = 1'b1; return -lim; end
        return v;
`else
        begin
            longint m;
            m = v & ((lim << 1) - 1);
            if (m >= lim) m = m - (lim << 1);
            return m;
        end
`endif
    endfunction

    function automatic longint model(input longint x, output bit h);
        bit h1, h2, h3;
        longint a;
        a = red(x * PA, h1);
        a = red(a + PB, h2);
        a = red(a * PC + PD, h3);
        h = h1 | h2 | h3;
        return a;
    endfunction

    // One cycle: drive at the falling edge, observe 1ns later, score transfers, advance one rising edge.
    task automatic tick(input bit iv, input longint x, input bit ordy, output bit acc);
        bit h;
        longint e;
        in_valid  = iv;
        X         = W'(x);
        out_ready = ordy;
        #1;
        obs_ov = out_valid;
        obs_ir = in_ready;
        obs_y  = Y;
        acc    = iv && in_ready;
        if (!rst) begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_y", Y, prev_y);
            end
            if (out_valid && out_ready) begin
                log_y.push_back(Y);
                log_c.push_back(cyc);
`ifdef AFFINE_PIPE_SAT_EN
                log_h.push_back(sat_hit);
`endif
                if (q_y.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else begin
                    e = q_y.pop_front();
                    h = q_h.pop_front();
                    check("y_vs_model", Y, e);
`ifdef AFFINE_PIPE_SAT_EN
                    check("sat_hit_vs_model", sat_hit, h);
`endif
                end
            end
            if (acc) begin
                e = model(x, h);
                q_y.push_back(e);
                q_h.push_back(h);
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = Y;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        if (rst) begin
            q_y.delete();
            q_h.delete();
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b1, a);
    endtask

    task automatic clear_log();
        log_y.delete();
        log_c.delete();
        log_h.delete();
    endtask

    initial begin
        bit acc, started, stalled, was_stalled, saw_low;
        int nx, stall_left, nacc;
        logic signed [W-1:0] rx;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; X = '0;
        prev_stall = 1'b0; prev_y = 0;
        @(negedge clk);

        // Reset: in_valid ignored, in_ready low, outputs cleared
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 5, 1'b1, acc);
            check("rst_in_ready", obs_ir, 0);
            check("rst_out_valid", obs_ov, 0);
            check("rst_y", obs_y, 0);
        end
        rst = 1'b0;
        tick(1'b0, 0, 1'b0, acc);
        check("empty_ir_ordy0", obs_ir, 1);
        check("empty_ov", obs_ov, 0);
        tick(1'b0, 0, 1'b1, acc);
        check("empty_ir_ordy1", obs_ir, 1);

        // Single sample latency and one-cycle pulse
        tick(1'b1, 1, 1'b1, acc);
        check("x1_accept", acc, 1);
        for (int k = 1; k <= 5; k++) begin
            tick(1'b0, 0, 1'b1, acc);
            check("x1_latency_ov", obs_ov, k == 4);
            if (k == 4) check("x1_y", obs_y, 23);
        end
        tick(1'b1, -4, 1'b1, acc);
        for (int k = 1; k <= 5; k++) begin
            tick(1'b0, 0, 1'b1, acc);
            check("xm4_latency_ov", obs_ov, k == 4);
            if (k == 4) check("xm4_y", obs_y, -7);
        end

        // Back-to-back stream
        clear_log();
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, i, 1'b1, acc);
            check("stream_ir", obs_ir, 1);
        end
        drain(6);
        check("stream_count", log_y.size(), 8);
        for (int i = 0; i < 8 && i < log_y.size(); i++) begin
            check("stream_y", log_y[i], 6 * i + 17);
            check("stream_consecutive", log_c[i] - log_c[0], i);
        end

        // Stream with a 5-cycle output stall starting at the first result
        clear_log();
        nx = 0; started = 0; stall_left = 5; was_stalled = 0; saw_low = 0;
        for (int t = 0; t < 40 && log_y.size() < 8; t++) begin
            if (!started && out_valid) started = 1'b1;
            stalled = started && (stall_left > 0);
            if (stalled) stall_left--;
            tick(nx < 8, nx, !stalled, acc);
            if (stalled) check("stall_hold_17", obs_y, 17);
            if (stalled && !obs_ir && !saw_low) begin
                saw_low = 1'b1;
                check("full_at_4", q_y.size(), 4);
            end
            if (!stalled && was_stalled) begin
                check("release_ir", obs_ir, 1);
                check("release_accept", acc, 1);
            end
            was_stalled = stalled;
            if (acc) nx++;
        end
        check("stall_ir_fell", saw_low, 1);
        check("stall_count", log_y.size(), 8);
        for (int i = 0; i < 8 && i < log_y.size(); i++) check("stall_y_order", log_y[i], 6 * i + 17);

        // Overflow behaviour
        clear_log();
        tick(1'b1, 20000, 1'b1, acc);
        drain(6);
        check("ovf_count", log_y.size(), 1);
`ifdef AFFINE_PIPE_SAT_EN
        check("ovf_y_sat", log_y[0], 32767);
        check("ovf_sat_hit", log_h[0], 1);
        clear_log();
        tick(1'b1, 1, 1'b1, acc);
        drain(6);
        check("x1_sat_hit", log_h[0], 0);
`else
        check("ovf_y_wrap", log_y[0], -11055);
`endif

        // Reset with samples in flight
        for (int i = 0; i < 3; i++) tick(1'b1, 10 + i, 1'b1, acc);
        rst = 1'b1;
        tick(1'b0, 0, 1'b0, acc);
        rst = 1'b0;
        tick(1'b0, 0, 1'b1, acc);
        check("midrst_ov", obs_ov, 0);
        check("midrst_y", obs_y, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 0, 1'b1, acc);
            check("midrst_no_stale", obs_ov, 0);
        end

        // Random traffic against the model
        nacc = 0;
        for (int t = 0; t < 60000 && nacc < 10000; t++) begin
            rx = W'($urandom);
            tick(1'($urandom_range(0, 1)), rx, 1'($urandom_range(0, 1)), acc);
            if (acc) nacc++;
        end
        check("rand_accepted", nacc, 10000);
        drain(10);
        check("rand_drained", q_y.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
